div_seq: RTL and testbench

- Iterative 32-bit divider sequencer for the execute stage. It handles signed and unsigned division using one radix-2 restoring step per cycle.
- Accepts a start request from the EX stage and runs a FSM plus iteration counter. While busy it raises a stall request to the pipeline stall controller (feeds ex_suspend_signal).
- Returns {remainder, quotient} with a ready handshake.

---
 rtl/div_seq.sv | 138 +++++++++++++
 tb/tb_div_seq.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// Iterative radix-2 restoring divider for the execute stage: one quotient bit per
// cycle, signed or unsigned, with a start/ready handshake and a pipeline stall request.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stallreq_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic             neg_quo;
  logic             neg_rem;

  logic [WIDTH-1:0] op1_abs;
  logic [WIDTH-1:0] op2_abs;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   diff;
  logic             take;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] quo_final;
  logic [WIDTH-1:0] rem_final;

  assign stallreq_o = start_i & ~annul_i & ~ready_o;

  // Magnitudes feed the unsigned core; -0x80000000 wraps back to 0x80000000, which is
  // exactly the unsigned magnitude we want.
  always_comb begin
    op1_abs = opdata1_i;
    op2_abs = opdata2_i;
    if (signed_div_i && opdata1_i[WIDTH-1]) op1_abs = -opdata1_i;
    if (signed_div_i && opdata2_i[WIDTH-1]) op2_abs = -opdata2_i;
  end

  // One restoring step: the borrow out of the (WIDTH+1)-bit subtract decides the bit.
  always_comb begin
    rem_shift = {rem, dividend[WIDTH-1]};
    diff      = rem_shift - {1'b0, divisor};
    take      = ~diff[WIDTH];
    rem_next  = take ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    quo_next  = {quo[WIDTH-2:0], take};
    quo_final = neg_quo ? -quo_next : quo_next;
    rem_final = neg_rem ? -rem_next : rem_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FREE;
      cnt      <= '0;
      dividend <= '0;
      divisor  <= '0;
      rem      <= '0;
      quo      <= '0;
      neg_quo  <= 1'b0;
      neg_rem  <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        FREE: begin
          result_o <= '0;
          ready_o  <= 1'b0;
          cnt      <= '0;
          if (start_i && !annul_i) begin
            if (opdata2_i == '0) begin
              state <= BYZERO;
            end else begin
              state    <= ON;
              dividend <= op1_abs;
              divisor  <= op2_abs;
              rem      <= '0;
              quo      <= '0;
              neg_quo  <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
              neg_rem  <= signed_div_i & opdata1_i[WIDTH-1];
            end
          end
        end
        BYZERO: begin
          if (annul_i) begin
            state <= FREE;
            cnt   <= '0;
          end else begin
            state    <= END;
            result_o <= '0;
            ready_o  <= 1'b1;
          end
        end
        ON: begin
          // Annul wins even on the final step, so a flushed divide never signals ready.
          if (annul_i) begin
            state <= FREE;
            cnt   <= '0;
          end else begin
            dividend <= {dividend[WIDTH-2:0], 1'b0};
            rem      <= rem_next;
            quo      <= quo_next;
            cnt      <= cnt + 1'b1;
            if (cnt == CW'(WIDTH - 1)) begin
              state    <= END;
              result_o <= {rem_final, quo_final};
              ready_o  <= 1'b1;
            end
          end
        end
        END: begin
          if (!start_i) begin
            state    <= FREE;
            result_o <= '0;
            ready_o  <= 1'b0;
          end
        end
        default: begin
          state    <= FREE;
          result_o <= '0;
          ready_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq: hand-computed quotient/remainder pairs,
// cycle-exact latency and stall checks, divide-by-zero, annul and mid-divide reset.
module tb_div_seq;

  logic        clk;
  logic        rst;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;
  logic        stallreq;

  int checks = 0;
  int errors = 0;

  div_seq #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (opdata1),
    .opdata2_i    (opdata2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready),
    .stallreq_o   (stallreq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Runs one divide from cycle 0, measures the cycle ready rises, checks stall and
  // result, then drops start and checks the return to idle.
  task automatic applyStimulus(input string tag, input logic sgn, input logic [31:0] a,
                               input logic [31:0] b, input logic scramble,
                               input logic [63:0] expected, input int exp_lat);
    int lat;
    int stall_low;
    @(posedge clk); #1;
    signed_div = sgn;
    opdata1    = a;
    opdata2    = b;
    start      = 1'b1;
    #1 checkOutput({tag, " stall c0"}, 64'(stallreq), 64'd1);
    lat = 0;
    stall_low = 0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (scramble) begin
        opdata1    = $urandom;
        opdata2    = $urandom;
        signed_div = ~signed_div;
      end
      if (ready) begin
        lat = n;
        break;
      end
      if (!stallreq) stall_low++;
    end
    checkOutput({tag, " latency"}, 64'(lat), 64'(exp_lat));
    checkOutput({tag, " stall busy"}, 64'(stall_low), 64'd0);
    checkOutput({tag, " result"}, result, expected);
    checkOutput({tag, " stall ready"}, 64'(stallreq), 64'd0);
    @(posedge clk); #1;
    checkOutput({tag, " hold ready"}, 64'(ready), 64'd1);
    start = 1'b0;
    @(posedge clk); #1;
    checkOutput({tag, " idle ready"}, 64'(ready), 64'd0);
    checkOutput({tag, " idle result"}, result, 64'd0);
  endtask

  // Watches an idle window in which a correctly aborted divide must never complete.
  task automatic watchIdle(input string tag);
    int seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (ready || result != 64'd0) seen++;
    end
    checkOutput({tag, " no ready"}, 64'(seen), 64'd0);
  endtask

  initial begin
    rst = 1'b1; signed_div = 1'b0; opdata1 = '0; opdata2 = '0; start = 1'b0; annul = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("reset ready", 64'(ready), 64'd0);
    checkOutput("reset result", result, 64'd0);
    checkOutput("reset stall", 64'(stallreq), 64'd0);

    applyStimulus("u100/7",   1'b0, 32'd100,        32'd7,          1'b0, {32'h2, 32'hE}, 33);
    applyStimulus("s-7/2",    1'b1, 32'hFFFFFFF9,   32'h2,          1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33);
    applyStimulus("s7/-2",    1'b1, 32'h7,          32'hFFFFFFFE,   1'b0, {32'h1, 32'hFFFFFFFD}, 33);
    applyStimulus("divzero",  1'b0, 32'd12345,      32'd0,          1'b0, 64'd0, 2);
    applyStimulus("s min/-1", 1'b1, 32'h80000000,   32'hFFFFFFFF,   1'b0, {32'h0, 32'h80000000}, 33);
    applyStimulus("u min/-1", 1'b0, 32'h80000000,   32'hFFFFFFFF,   1'b0, {32'h80000000, 32'h0}, 33);

    // Annul pulsed in cycle 10 of a divide.
    @(posedge clk); #1;
    signed_div = 1'b0; opdata1 = 32'd999; opdata2 = 32'd3; start = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
    end
    annul = 1'b1;
    #1 checkOutput("annul stall", 64'(stallreq), 64'd0);
    @(posedge clk); #1;
    annul = 1'b0;
    start = 1'b0;
    checkOutput("annul ready", 64'(ready), 64'd0);
    watchIdle("annul");
    applyStimulus("u1000/10", 1'b0, 32'd1000,       32'd10,         1'b0, {32'h0, 32'h64}, 33);

    // Reset asserted in cycle 20 of a divide.
    @(posedge clk); #1;
    signed_div = 1'b1; opdata1 = 32'd5000; opdata2 = 32'd7; start = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst ready", 64'(ready), 64'd0);
    checkOutput("rst result", result, 64'd0);
    rst = 1'b0;
    start = 1'b0;
    watchIdle("rst");
    applyStimulus("uFFFF/16", 1'b0, 32'hFFFFFFFF,   32'h10,         1'b1, {32'hF, 32'h0FFFFFFF}, 33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
